// File: rtl/arty_exit_pkg.sv
// -----------------------------------------------------------------------------
// arty_exit_pkg
// Shared definitions for the Arty exit monitor: FSM state encoding, the
// tohost exit-bit position, the exit code reported on a cycle-limit timeout,
// and the bit positions of the four status LEDs.
// -----------------------------------------------------------------------------
package arty_exit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  // Bit 0 of a tohost payload marks an exit write; bits [31:1] carry the code.
  localparam int unsigned EXIT_BIT = 0;

  // Exit code reported when the run is stopped by the cycle limit.
  localparam logic [30:0] TIMEOUT_CODE = 31'h7FFF_FFFF;

  // Status LED bit positions.
  localparam int unsigned LED_HB   = 0;
  localparam int unsigned LED_RUN  = 1;
  localparam int unsigned LED_PASS = 2;
  localparam int unsigned LED_FAIL = 3;

endpackage : arty_exit_pkg

// File: rtl/arty_heartbeat_div.sv
// -----------------------------------------------------------------------------
// arty_heartbeat_div
// Free-running divider that toggles its output every HB_DIV clock cycles,
// giving a visible "alive" blink on the board. Only built when the top is
// compiled with ARTY_EXIT_MON_HEARTBEAT_EN defined.
//
// Ports:
//   clock  in  1  system clock
//   reset  in  1  synchronous, active-low reset (clears divider and output)
//   hb_o   out 1  heartbeat level, half-period HB_DIV cycles
// -----------------------------------------------------------------------------
module arty_heartbeat_div #(
  parameter int unsigned HB_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  output logic hb_o
);

  // A divider of 0 would never wrap; treat it as 1 (toggle every cycle).
  localparam int unsigned DIV   = (HB_DIV < 1) ? 1 : HB_DIV;
  localparam int unsigned CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hb_q,  hb_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    hb_d  = hb_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
      hb_d  = ~hb_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      hb_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hb_q  <= hb_d;
    end
  end

  assign hb_o = hb_q;

endmodule : arty_heartbeat_div

// File: rtl/arty_exit_monitor.sv
// -----------------------------------------------------------------------------
// arty_exit_monitor
// Harness-side status block. Watches the DUT's tohost write channel, decodes
// exit writes into sticky pass/fail status, enforces an optional cycle limit,
// counts RUN cycles and drives the Arty status LEDs.
//
// Optional build macro: ARTY_EXIT_MON_HEARTBEAT_EN
//   defined   -> led[0] blinks from an arty_heartbeat_div (half-period HB_DIV)
//   undefined -> led[0] tied low, no divider logic
//
// Parameters:
//   CNT_W       width of the RUN cycle counter
//   MAX_CYCLES  RUN-cycle limit before timeout; 0 disables the limit
//   HB_DIV      heartbeat half-period in clock cycles (>= 1)
//
// Ports:
//   clock         in   1      system clock
//   reset         in   1      synchronous, active-low reset
//   enable        in   1      arms the monitor; only looked at in IDLE
//   tohost_valid  in   1      DUT write valid
//   tohost_data   in   32     DUT write payload
//   tohost_ready  out  1      write accepted when valid && ready
//   success       out  1      sticky, test passed
//   failure       out  1      sticky, test failed or timed out
//   timeout       out  1      sticky, failure caused by the cycle limit
//   exit_code     out  31     decoded exit code (payload[31:1])
//   cycle_count   out  CNT_W  RUN cycles elapsed
//   led           out  4      [0] heartbeat [1] running [2] pass [3] fail
// -----------------------------------------------------------------------------
module arty_exit_monitor
  import arty_exit_pkg::*;
#(
  parameter int unsigned      CNT_W      = 64,
  parameter longint unsigned  MAX_CYCLES = 0,
  parameter int unsigned      HB_DIV     = 50000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tohost_valid,
  input  logic [31:0]      tohost_data,
  output logic             tohost_ready,
  output logic             success,
  output logic             failure,
  output logic             timeout,
  output logic [30:0]      exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [3:0]       led
);

  localparam bit               LIMIT_EN  = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q,     state_d;
  logic             success_q,   success_d;
  logic             failure_q,   failure_d;
  logic             timeout_q,   timeout_d;
  logic [30:0]      exit_code_q, exit_code_d;
  logic [CNT_W-1:0] count_q,     count_d;

  logic             accept;
  logic             exit_wr;
  logic             led_hb;

  // The channel is open in every state except IDLE; terminal states keep
  // accepting so a misbehaving DUT cannot stall on its own exit write.
  assign tohost_ready = (state_q != ST_IDLE);
  assign accept       = tohost_valid && tohost_ready;
  assign exit_wr      = accept && tohost_data[EXIT_BIT];

  always_comb begin
    state_d     = state_q;
    exit_code_d = exit_code_q;
    count_d     = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Priority: exit write, then cycle limit, then ordinary counting.
        // Both terminal transitions freeze the counter on their edge.
        if (exit_wr) begin
          exit_code_d = tohost_data[31:1];
          state_d     = (tohost_data[31:1] == 31'd0) ? ST_PASS : ST_FAIL;
        end else if (LIMIT_EN && (count_q >= LIMIT)) begin
          exit_code_d = TIMEOUT_CODE;
          state_d     = ST_TIMEOUT;
        end else if (count_q != CNT_MAX) begin
          count_d = count_q + 1'b1;
        end
      end

      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        state_d = state_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they appear in the
    // cycle right after the transition edge, together with state_q.
    success_d = (state_d == ST_PASS);
    failure_d = (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      success_q   <= 1'b0;
      failure_q   <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      success_q   <= success_d;
      failure_q   <= failure_d;
      timeout_q   <= timeout_d;
      exit_code_q <= exit_code_d;
      count_q     <= count_d;
    end
  end

`ifdef ARTY_EXIT_MON_HEARTBEAT_EN
  arty_heartbeat_div #(
    .HB_DIV (HB_DIV)
  ) u_hb (
    .clock (clock),
    .reset (reset),
    .hb_o  (led_hb)
  );
`else
  assign led_hb = 1'b0;
`endif

  assign success     = success_q;
  assign failure     = failure_q;
  assign timeout     = timeout_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = count_q;

  always_comb begin
    led           = 4'b0000;
    led[LED_HB]   = led_hb;
    led[LED_RUN]  = (state_q == ST_RUN);
    led[LED_PASS] = success_q;
    led[LED_FAIL] = failure_q;
  end

endmodule : arty_exit_monitor

// File: tb/tb_arty_exit_monitor.sv
// -----------------------------------------------------------------------------
// tb_arty_exit_monitor
// Directed bench for arty_exit_monitor. Two instances share all inputs:
// u_free has no cycle limit, u_lim stops after 10 RUN cycles. Expected status
// is queued when stimulus is applied and compared after the following edge.
// led[0] (heartbeat) is masked out of status comparisons.
// -----------------------------------------------------------------------------
module tb_arty_exit_monitor;

  localparam int CNT_W = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        tohost_valid = 1'b0;
  logic [31:0] tohost_data = 32'd0;

  logic             f_ready, f_success, f_failure, f_timeout;
  logic [30:0]      f_code;
  logic [CNT_W-1:0] f_count;
  logic [3:0]       f_led;

  logic             l_ready, l_success, l_failure, l_timeout;
  logic [30:0]      l_code;
  logic [CNT_W-1:0] l_count;
  logic [3:0]       l_led;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  arty_exit_monitor #(.CNT_W(CNT_W), .MAX_CYCLES(0), .HB_DIV(4)) u_free (
    .clock(clock), .reset(reset), .enable(enable),
    .tohost_valid(tohost_valid), .tohost_data(tohost_data),
    .tohost_ready(f_ready), .success(f_success), .failure(f_failure),
    .timeout(f_timeout), .exit_code(f_code), .cycle_count(f_count), .led(f_led)
  );

  arty_exit_monitor #(.CNT_W(CNT_W), .MAX_CYCLES(10), .HB_DIV(4)) u_lim (
    .clock(clock), .reset(reset), .enable(enable),
    .tohost_valid(tohost_valid), .tohost_data(tohost_data),
    .tohost_ready(l_ready), .success(l_success), .failure(l_failure),
    .timeout(l_timeout), .exit_code(l_code), .cycle_count(l_count), .led(l_led)
  );

  typedef struct {
    string       tag;
    int          dut;   // 0 = u_free, 1 = u_lim
    logic        rdy;
    logic        s;
    logic        f;
    logic        t;
    logic [30:0] code;
    logic [63:0] cnt;
    logic [3:0]  led;
  } exp_t;

  exp_t sb[$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic expect_st(string tag, int dut, logic rdy, logic s, logic f,
                           logic t, logic [30:0] code, logic [63:0] cnt,
                           logic [3:0] led);
    exp_t e;
    e.tag = tag; e.dut = dut; e.rdy = rdy; e.s = s; e.f = f; e.t = t;
    e.code = code; e.cnt = cnt; e.led = led;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic        rdy, s, f, t;
    logic [30:0] code;
    logic [63:0] cnt;
    logic [3:0]  led;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        rdy = f_ready; s = f_success; f = f_failure; t = f_timeout;
        code = f_code; cnt = f_count; led = f_led;
      end else begin
        rdy = l_ready; s = l_success; f = l_failure; t = l_timeout;
        code = l_code; cnt = l_count; led = l_led;
      end
      check({e.tag, "/ready"},   64'(rdy),  64'(e.rdy));
      check({e.tag, "/success"}, 64'(s),    64'(e.s));
      check({e.tag, "/failure"}, 64'(f),    64'(e.f));
      check({e.tag, "/timeout"}, 64'(t),    64'(e.t));
      check({e.tag, "/code"},    64'(code), 64'(e.code));
      check({e.tag, "/count"},   cnt,       e.cnt);
      check({e.tag, "/led"},     64'(led & 4'b1110), 64'(e.led));
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0; enable = 1'b0; tohost_valid = 1'b0; tohost_data = 32'd0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    expect_st("reset_free", 0, 0, 0, 0, 0, 31'd0, 64'd0, 4'b0000);
    expect_st("reset_lim",  1, 0, 0, 0, 0, 31'd0, 64'd0, 4'b0000);
    drain();

    // IDLE hold with enable low
    reset = 1'b1;
    repeat (20) step();
    expect_st("idle_free", 0, 0, 0, 0, 0, 31'd0, 64'd0, 4'b0000);
    expect_st("idle_lim",  1, 0, 0, 0, 0, 31'd0, 64'd0, 4'b0000);
    drain();

    // Enter RUN; deasserting enable afterwards is ignored
    enable = 1'b1;
    step();
    enable = 1'b0;
    expect_st("run_entry", 0, 1, 0, 0, 0, 31'd0, 64'd0, 4'b0010);
    drain();
    repeat (5) step();

    // Non-exit write is consumed and counting continues
    tohost_valid = 1'b1; tohost_data = 32'h0000_0100;
    expect_st("nonexit_free", 0, 1, 0, 0, 0, 31'd0, 64'd6, 4'b0010);
    expect_st("nonexit_lim",  1, 1, 0, 0, 0, 31'd0, 64'd6, 4'b0010);
    step();
    drain();

    // Pass exit: counter freezes on the exit edge
    tohost_data = 32'h0000_0001;
    expect_st("pass_free", 0, 1, 1, 0, 0, 31'd0, 64'd6, 4'b0100);
    expect_st("pass_lim",  1, 1, 1, 0, 0, 31'd0, 64'd6, 4'b0100);
    step();
    tohost_valid = 1'b0;
    drain();
    repeat (3) step();
    expect_st("pass_hold", 0, 1, 1, 0, 0, 31'd0, 64'd6, 4'b0100);
    drain();

    // Reset mid-run at count 7
    reset_pulse();
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (7) step();
    expect_st("run_at7", 0, 1, 0, 0, 0, 31'd0, 64'd7, 4'b0010);
    drain();
    reset = 1'b0;
    step();
    reset = 1'b1;
    expect_st("midrun_reset_free", 0, 0, 0, 0, 0, 31'd0, 64'd0, 4'b0000);
    expect_st("midrun_reset_lim",  1, 0, 0, 0, 0, 31'd0, 64'd0, 4'b0000);
    drain();

    // Fail exit 0xB -> code 5, later pass-looking writes ignored
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (3) step();
    tohost_valid = 1'b1; tohost_data = 32'h0000_000B;
    expect_st("fail_exit", 0, 1, 0, 1, 0, 31'd5, 64'd3, 4'b1000);
    step();
    drain();
    tohost_data = 32'h0000_0001;
    repeat (2) step();
    tohost_valid = 1'b0;
    expect_st("fail_sticky", 0, 1, 0, 1, 0, 31'd5, 64'd3, 4'b1000);
    drain();

    // Timeout after 10 RUN cycles on u_lim; u_free keeps running
    reset_pulse();
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (10) step();
    expect_st("pre_timeout", 1, 1, 0, 0, 0, 31'd0, 64'd10, 4'b0010);
    drain();
    expect_st("timeout_lim",  1, 1, 0, 1, 1, 31'h7FFF_FFFF, 64'd10, 4'b1000);
    expect_st("timeout_free", 0, 1, 0, 0, 0, 31'd0,         64'd11, 4'b0010);
    step();
    drain();
    repeat (5) step();
    expect_st("timeout_hold", 1, 1, 0, 1, 1, 31'h7FFF_FFFF, 64'd10, 4'b1000);
    expect_st("nolimit_run",  0, 1, 0, 0, 0, 31'd0,         64'd16, 4'b0010);
    drain();

    // Exit write on the same cycle the limit is reached: exit wins
    reset_pulse();
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (10) step();
    tohost_valid = 1'b1; tohost_data = 32'h0000_0001;
    expect_st("tie_lim",  1, 1, 1, 0, 0, 31'd0, 64'd10, 4'b0100);
    expect_st("tie_free", 0, 1, 1, 0, 0, 31'd0, 64'd10, 4'b0100);
    step();
    tohost_valid = 1'b0;
    drain();

`ifdef ARTY_EXIT_MON_HEARTBEAT_EN
    // Heartbeat restarts from reset and toggles every 4 cycles
    reset_pulse();
    check("hb_after_reset", 64'(f_led[0]), 64'd0);
    repeat (3) step();
    check("hb_before_4", 64'(f_led[0]), 64'd0);
    step();
    check("hb_at_4", 64'(f_led[0]), 64'd1);
    repeat (4) step();
    check("hb_at_8", 64'(l_led[0]), 64'd0);
`else
    check("hb_tied_low", 64'(f_led[0] | l_led[0]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_arty_exit_monitor
